// File: rtl/pc_source_sel_pkg.sv
// Shared fetch-pipeline constants: PC geometry, reset vector and PC source indices.
package pc_source_sel_pkg;
  localparam int          NBITS      = 32;
  localparam int          PC_STEP    = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          SRC_SEQ    = 0;
  localparam int          SRC_BRANCH = 1;
  localparam int          SRC_JUMP   = 2;
  localparam int          SRC_JR     = 3;
endpackage

// File: rtl/prio_mux_n.sv
// Combinational priority mux: the highest-index asserted request wins and its target slice is forwarded.
module prio_mux_n #(
  parameter int NBITS = 32,
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-2:0]       req,
  input  logic [N_SRC*NBITS-1:0] targets,
  output logic                   valid,
  output logic [$clog2(N_SRC)-1:0] idx,
  output logic [NBITS-1:0]       target
);
  localparam int SW = $clog2(N_SRC);

  // Source 0 is the sequential path and never requests, so its slot is forced low.
  logic [N_SRC-1:0] req_full;
  assign req_full = {req, 1'b0};

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    target = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (req_full[k]) begin
        valid  = 1'b1;
        idx    = SW'(k);
        target = targets[k*NBITS +: NBITS];
      end
    end
  end
endmodule

// File: rtl/pc_source_sel.sv
// Registered PC source selector with stall hold and a one-entry redirect buffer.
// Optional target alignment filter: define PC_SRC_ALIGN_CHECK_EN.
module pc_source_sel
  import pc_source_sel_pkg::*;
#(
  parameter int               NBITS    = pc_source_sel_pkg::NBITS,
  parameter int               N_SRC    = 4,
  parameter int               PC_STEP  = pc_source_sel_pkg::PC_STEP,
  parameter logic [NBITS-1:0] RESET_PC = pc_source_sel_pkg::RESET_PC
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stall,
  input  logic [N_SRC-2:0]         i_req,
  input  logic [N_SRC*NBITS-1:0]   i_target,
  output logic [NBITS-1:0]         o_pc,
  output logic [$clog2(N_SRC)-1:0] o_src,
  output logic                     o_pending,
  output logic                     o_misaligned
);
  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-2:0] req_ok;
  logic             live_valid;
  logic [SW-1:0]    live_idx;
  logic [NBITS-1:0] live_tgt;

  logic             pend_valid_reg, pend_valid_next;
  logic [SW-1:0]    pend_idx_reg, pend_idx_next;
  logic [NBITS-1:0] pend_tgt_reg, pend_tgt_next;
  logic [NBITS-1:0] pc_next;
  logic [SW-1:0]    src_next;
  logic             take_live;

`ifdef PC_SRC_ALIGN_CHECK_EN
  localparam logic [NBITS-1:0] ALIGN_MASK = NBITS'(PC_STEP - 1);
`endif

  for (genvar gi = 1; gi < N_SRC; gi++) begin : g_align
`ifdef PC_SRC_ALIGN_CHECK_EN
    assign req_ok[gi-1] = i_req[gi-1] && ((i_target[gi*NBITS +: NBITS] & ALIGN_MASK) == '0);
`else
    assign req_ok[gi-1] = i_req[gi-1];
`endif
  end

  prio_mux_n #(.NBITS(NBITS), .N_SRC(N_SRC)) u_live_mux (
    .req     (req_ok),
    .targets (i_target),
    .valid   (live_valid),
    .idx     (live_idx),
    .target  (live_tgt)
  );

  // Equal index favours the live request: it is the newer of the two.
  assign take_live = live_valid && (!pend_valid_reg || (live_idx >= pend_idx_reg));

  always_comb begin
    pc_next         = o_pc;
    src_next        = o_src;
    pend_valid_next = pend_valid_reg;
    pend_idx_next   = pend_idx_reg;
    pend_tgt_next   = pend_tgt_reg;
    if (i_stall) begin
      if (take_live) begin
        pend_valid_next = 1'b1;
        pend_idx_next   = live_idx;
        pend_tgt_next   = live_tgt;
      end
    end else begin
      pend_valid_next = 1'b0;
      pend_idx_next   = '0;
      pend_tgt_next   = '0;
      if (take_live) begin
        pc_next  = live_tgt;
        src_next = live_idx;
      end else if (pend_valid_reg) begin
        pc_next  = pend_tgt_reg;
        src_next = pend_idx_reg;
      end else begin
        pc_next  = o_pc + NBITS'(PC_STEP);
        src_next = SW'(SRC_SEQ);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc           <= RESET_PC;
      o_src          <= SW'(SRC_SEQ);
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
      pend_tgt_reg   <= '0;
    end else begin
      o_pc           <= pc_next;
      o_src          <= src_next;
      pend_valid_reg <= pend_valid_next;
      pend_idx_reg   <= pend_idx_next;
      pend_tgt_reg   <= pend_tgt_next;
    end
  end

  assign o_pending = pend_valid_reg;

`ifdef PC_SRC_ALIGN_CHECK_EN
  logic misaligned_reg;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) misaligned_reg <= 1'b0;
    else         misaligned_reg <= |(i_req & ~req_ok);
  end
  assign o_misaligned = misaligned_reg;
`else
  assign o_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_pc_source_sel.sv
// Self-checking bench for pc_source_sel: directed scenarios plus randomized traffic against a reference model.
module tb_pc_source_sel;
  localparam int NB = 32;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic [NS-2:0]   req = '0;
  logic [NS*NB-1:0] target = '0;
  logic [NB-1:0]   pc;
  logic [1:0]      src;
  logic            pending;
  logic            misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_src;
  bit          m_pv;
  int          m_pi;
  logic [31:0] m_pt;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_source_sel dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_stall     (stall),
    .i_req       (req),
    .i_target    (target),
    .o_pc        (pc),
    .o_src       (src),
    .o_pending   (pending),
    .o_misaligned(misaligned)
  );

  task automatic set_tgt(input int k, input logic [31:0] t);
    target[k*NB +: NB] = t;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    $display("[%0t] %s pc=%h src=%0d pend=%b mis=%b", $time, tag, pc, src, pending, misaligned);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_src = 0; m_pv = 0; m_pi = 0; m_pt = 32'h0; m_mis = 0;
  endtask

  // Behavioural rules: pick the best eligible live request, then resolve against the buffer.
  task automatic model_edge();
    int best;
    logic [31:0] best_t, t;
    bit rejected;
    best = 0; best_t = 32'h0; rejected = 0;
    for (int k = 1; k < NS; k++) begin
      t = target[k*NB +: NB];
      if (req[k-1]) begin
`ifdef PC_SRC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
          rejected = 1;
          continue;
        end
`endif
        best = k; best_t = t;
      end
    end
    m_mis = rejected;
    if (stall) begin
      if (best != 0 && (!m_pv || best >= m_pi)) begin
        m_pv = 1; m_pi = best; m_pt = best_t;
      end
    end else begin
      if (best != 0 && (!m_pv || best >= m_pi)) begin
        m_pc = best_t; m_src = best;
      end else if (m_pv) begin
        m_pc = m_pt; m_src = m_pi;
      end else begin
        m_pc = m_pc + 32'd4; m_src = 0;
      end
      m_pv = 0;
    end
  endtask

  task automatic do_reset();
    req = '0; stall = 0; target = '0;
    #2 rst = 1;
    #2 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1;
    #3;
    checks++;
    if (pc !== 32'h0 || src !== 2'd0 || pending !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h src=%0d pend=%b mis=%b required pc=0 src=0 pend=0 mis=0",
               pc, src, pending, misaligned);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      tick("seq");
      exp_pc = 32'(i * 4);
      checks++;
      if (pc !== exp_pc || src !== 2'd0) begin
        errors++;
        $display("FAIL seq_fetch: got pc=%h src=%0d required pc=%h src=0", pc, src, exp_pc);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick("seq"); tick("seq");
    checks++;
    if (pc !== 32'h8) begin
      errors++;
      $display("FAIL simul_setup: got pc=%h required 00000008", pc);
    end
    req = 3'b011;
    set_tgt(1, 32'h8c01_0000);
    set_tgt(2, 32'h0000_0040);
    tick("simul");
    req = '0;
    checks++;
    if (pc !== 32'h40 || src !== 2'd2) begin
      errors++;
      $display("FAIL simul_redirect: got pc=%h src=%0d required pc=00000040 src=2", pc, src);
    end
  endtask

  task automatic test_stall_buffer();
    logic [31:0] held;
    do_reset();
    tick("seq");
    held = pc;
    stall = 1; req = 3'b001; set_tgt(1, 32'h100);
    tick("stall_s1");
    checks++;
    if (pending !== 1'b1 || pc !== held) begin
      errors++;
      $display("FAIL stall_cap1: got pend=%b pc=%h required pend=1 pc=%h", pending, pc, held);
    end
    req = 3'b010; set_tgt(2, 32'h200);
    tick("stall_s2");
    checks++;
    if (pending !== 1'b1 || pc !== held) begin
      errors++;
      $display("FAIL stall_cap2: got pend=%b pc=%h required pend=1 pc=%h", pending, pc, held);
    end
    req = '0; stall = 0;
    tick("release");
    checks++;
    if (pc !== 32'h200 || src !== 2'd2 || pending !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got pc=%h src=%0d pend=%b required pc=00000200 src=2 pend=0",
               pc, src, pending);
    end
  endtask

  task automatic test_priority_buffer();
    do_reset();
    tick("seq");
    stall = 1; req = 3'b100; set_tgt(3, 32'h300);
    tick("stall_s3");
    stall = 0; req = 3'b001; set_tgt(1, 32'h500);
    tick("release");
    req = '0;
    checks++;
    if (pc !== 32'h300 || src !== 2'd3 || pending !== 1'b0) begin
      errors++;
      $display("FAIL prio_buffer: got pc=%h src=%0d pend=%b required pc=00000300 src=3 pend=0",
               pc, src, pending);
    end
    tick("seq");
    checks++;
    if (pc !== 32'h304 || src !== 2'd0) begin
      errors++;
      $display("FAIL prio_after: got pc=%h src=%0d required pc=00000304 src=0", pc, src);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    req = 3'b001; set_tgt(1, 32'hFFFF_FFFC);
    tick("jump_top");
    req = '0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup: got pc=%h required fffffffc", pc);
    end
    tick("wrap");
    checks++;
    if (pc !== 32'h0 || src !== 2'd0) begin
      errors++;
      $display("FAIL wrap: got pc=%h src=%0d required pc=00000000 src=0", pc, src);
    end
    stall = 1; req = 3'b010; set_tgt(2, 32'h200);
    tick("stall_s2");
    req = '0;
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL midstall_cap: got pend=%b required 1", pending);
    end
    #1 rst = 1;
    #1;
    checks++;
    if (pending !== 1'b0 || pc !== 32'h0 || src !== 2'd0) begin
      errors++;
      $display("FAIL midstall_reset: got pend=%b pc=%h src=%0d required pend=0 pc=0 src=0",
               pending, pc, src);
    end
    rst = 0; stall = 0;
    tick("after_rst");
    checks++;
    if (pc !== 32'h4 || src !== 2'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got pc=%h src=%0d pend=%b required pc=00000004 src=0 pend=0",
               pc, src, pending);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_pc;
    logic [1:0]  exp_src;
    logic        exp_mis;
    do_reset();
    tick("seq");
    req = 3'b001; set_tgt(1, 32'h102);
`ifdef PC_SRC_ALIGN_CHECK_EN
    exp_pc = 32'h8; exp_src = 2'd0; exp_mis = 1'b1;
`else
    exp_pc = 32'h102; exp_src = 2'd1; exp_mis = 1'b0;
`endif
    tick("misalign");
    req = '0;
    checks++;
    if (pc !== exp_pc || src !== exp_src || misaligned !== exp_mis) begin
      errors++;
      $display("FAIL misalign_req: got pc=%h src=%0d mis=%b required pc=%h src=%0d mis=%b",
               pc, src, misaligned, exp_pc, exp_src, exp_mis);
    end
    tick("seq");
    checks++;
    if (pc !== exp_pc + 32'd4 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got pc=%h mis=%b required pc=%h mis=0",
               pc, misaligned, exp_pc + 32'd4);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
        model_reset();
        checks++;
        if (pc !== m_pc || pending !== 1'b0) begin
          errors++;
          $display("FAIL rand_reset: got pc=%h pend=%b required pc=%h pend=0", pc, pending, m_pc);
        end
      end
      stall = ($urandom_range(0, 9) < 4);
      req = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      for (int k = 1; k < NS; k++) begin
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        set_tgt(k, t);
      end
      model_edge();
      tick("rand");
      checks++;
      if (pc !== m_pc || src !== 2'(m_src) || pending !== m_pv || misaligned !== m_mis) begin
        errors++;
        $display("FAIL rand_cycle%0d: got pc=%h src=%0d pend=%b mis=%b required pc=%h src=%0d pend=%b mis=%b",
                 n, pc, src, pending, misaligned, m_pc, m_src, m_pv, m_mis);
      end
    end
    req = '0; stall = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_simultaneous();
    test_stall_buffer();
    test_priority_buffer();
    test_wrap_and_reset();
    test_misaligned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
